store_pack: RTL and testbench

Memory-stage store path that narrows and lane-aligns register data for `sb`/`sh`/`sw`, generating a word-aligned address and byte enables for the data memory port. It is the narrowing counterpart of the immediate/load extension path. It sits between the MEM-stage store issue and the data memory. A small in-order buffer decouples issue from memory back-pressure. Misaligned or illegal stores are rejected with an error pulse and are never written.

---
 rtl/store_pack.sv | 151 +++++++++++++++
 tb/tb_store_pack.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/store_pack.sv
// store_pack: MEM-stage store narrowing and lane alignment.
// Each request is turned into a word address, lane-replicated data and
// byte enables. Legal stores go into a small in-order buffer that feeds
// the data memory. Misaligned or illegal-size stores are dropped; each
// one raises a one-cycle Align_Err pulse and records its address.
module store_pack #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_Data,
  input  logic [1:0]  Req_Size,
  output logic        Mem_Valid,
  input  logic        Mem_Ready,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_Data,
  output logic [3:0]  Mem_BE,
  output logic        Align_Err,
  output logic [31:0] Err_Addr,
  output logic        Busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT_ZERO = (PW + 1)'(0);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  // Buffer storage: word address, replicated data and byte enables per entry.
  logic [31:0]   addr_mem_r [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [3:0]    be_mem_r   [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic          align_err_r;
  logic [31:0]   err_addr_r;

  logic          legal_s;
  logic [3:0]    be_s;
  logic [31:0]   data_s;
  logic          accept_s;
  logic          push_s;
  logic          reject_s;
  logic          pop_s;

  // Ready and memory-side outputs depend only on registers (and reset).
  assign Req_Ready = reset && (count_r != CNT_FULL);
  assign Mem_Valid = (count_r != CNT_ZERO);
  assign Busy      = Mem_Valid;
  assign Mem_Addr  = addr_mem_r[rd_ptr_r];
  assign Mem_Data  = data_mem_r[rd_ptr_r];
  assign Mem_BE    = be_mem_r[rd_ptr_r];
  assign Align_Err = align_err_r;
  assign Err_Addr  = err_addr_r;

  assign accept_s = Req_Valid && Req_Ready;
  assign push_s   = accept_s && legal_s;
  assign reject_s = accept_s && !legal_s;
  assign pop_s    = Mem_Valid && Mem_Ready;

  // Decode size and low address bits into legality, lane enables and data.
  always_comb begin
    legal_s = 1'b0;
    be_s    = 4'b0000;
    data_s  = 32'h0000_0000;
    case (Req_Size)
      2'b00: begin
        legal_s = 1'b1;
        be_s    = 4'b0001 << Req_Addr[1:0];
        data_s  = {4{Req_Data[7:0]}};
      end
      2'b01: begin
        legal_s = ~Req_Addr[0];
        be_s    = Req_Addr[1] ? 4'b1100 : 4'b0011;
        data_s  = {2{Req_Data[15:0]}};
      end
      2'b10: begin
        legal_s = (Req_Addr[1:0] == 2'b00);
        be_s    = 4'b1111;
        data_s  = Req_Data;
      end
      default: begin
        legal_s = 1'b0;
        be_s    = 4'b0000;
        data_s  = 32'h0000_0000;
      end
    endcase
  end

  // Write legal stores at the tail; reset wipes every entry so Mem_* read 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= 32'h0000_0000;
        data_mem_r[i] <= 32'h0000_0000;
        be_mem_r[i]   <= 4'b0000;
      end
    end else if (push_s) begin
      addr_mem_r[wr_ptr_r] <= {Req_Addr[31:2], 2'b00};
      data_mem_r[wr_ptr_r] <= data_s;
      be_mem_r[wr_ptr_r]   <= be_s;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Occupancy: push and pop in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= CNT_ZERO;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Error pulse lasts one cycle per reject; the address sticks until the next.
  always_ff @(posedge clk) begin
    if (!reset) begin
      align_err_r <= 1'b0;
      err_addr_r  <= 32'h0000_0000;
    end else begin
      align_err_r <= reject_s;
      if (reject_s) begin
        err_addr_r <= Req_Addr;
      end
    end
  end

endmodule

// File: tb/tb_store_pack.sv
// Directed bench for store_pack (DEPTH=2). Inputs change 1 time unit after
// a rising edge; outputs are checked at that point too, well clear of edges.
module tb_store_pack;

  logic        clk;
  logic        reset;
  logic        Req_Valid;
  logic        Req_Ready;
  logic [31:0] Req_Addr;
  logic [31:0] Req_Data;
  logic [1:0]  Req_Size;
  logic        Mem_Valid;
  logic        Mem_Ready;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_Data;
  logic [3:0]  Mem_BE;
  logic        Align_Err;
  logic [31:0] Err_Addr;
  logic        Busy;

  int total = 0;
  int bad   = 0;

  store_pack #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Addr(Req_Addr),
    .Req_Data(Req_Data), .Req_Size(Req_Size),
    .Mem_Valid(Mem_Valid), .Mem_Ready(Mem_Ready), .Mem_Addr(Mem_Addr),
    .Mem_Data(Mem_Data), .Mem_BE(Mem_BE),
    .Align_Err(Align_Err), .Err_Addr(Err_Addr), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    Req_Valid = v;
    Req_Addr  = a;
    Req_Data  = d;
    Req_Size  = s;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    chk({tag, "_valid"}, {31'd0, Mem_Valid}, 32'd1);
    chk({tag, "_addr"}, Mem_Addr, a);
    chk({tag, "_data"}, Mem_Data, d);
    chk({tag, "_be"}, {28'd0, Mem_BE}, {28'd0, be});
  endtask

  initial begin
    reset     = 1'b0;
    Mem_Ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    tick();
    // Reset state
    chk("rst_ready", {31'd0, Req_Ready}, 32'd0);
    chk("rst_mvalid", {31'd0, Mem_Valid}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_be", {28'd0, Mem_BE}, 32'd0);
    chk("rst_maddr", Mem_Addr, 32'd0);
    chk("rst_mdata", Mem_Data, 32'd0);
    chk("rst_aerr", {31'd0, Align_Err}, 32'd0);
    chk("rst_eaddr", Err_Addr, 32'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, Req_Ready}, 32'd1);

    // Byte lanes, a=3 first then a=0..2; one store per cycle with Mem_Ready=1
    Mem_Ready = 1'b1;
    drive(1'b1, 32'h0000_0103, 32'h1234_56AB, 2'b00);
    tick();
    chk_head("byte3", 32'h0000_0100, 32'hABAB_ABAB, 4'b1000);
    drive(1'b1, 32'h0000_0100, 32'h1234_56AB, 2'b00);
    tick();
    chk_head("byte0", 32'h0000_0100, 32'hABAB_ABAB, 4'b0001);
    drive(1'b1, 32'h0000_0101, 32'h1234_56AB, 2'b00);
    tick();
    chk_head("byte1", 32'h0000_0100, 32'hABAB_ABAB, 4'b0010);
    drive(1'b1, 32'h0000_0102, 32'h1234_56AB, 2'b00);
    tick();
    chk_head("byte2", 32'h0000_0100, 32'hABAB_ABAB, 4'b0100);

    // Half and word
    drive(1'b1, 32'h0000_0206, 32'h0000_BEEF, 2'b01);
    tick();
    chk_head("half", 32'h0000_0204, 32'hBEEF_BEEF, 4'b1100);
    drive(1'b1, 32'h0000_0300, 32'hDEAD_BEEF, 2'b10);
    tick();
    chk_head("word", 32'h0000_0300, 32'hDEAD_BEEF, 4'b1111);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    chk("drain_empty", {31'd0, Mem_Valid}, 32'd0);

    // Misaligned half, misaligned word, illegal size: three pulses
    drive(1'b1, 32'h0000_0101, 32'h1111_1111, 2'b01);
    tick();
    chk("err1_pulse", {31'd0, Align_Err}, 32'd1);
    chk("err1_addr", Err_Addr, 32'h0000_0101);
    drive(1'b1, 32'h0000_0102, 32'h2222_2222, 2'b10);
    tick();
    chk("err2_pulse", {31'd0, Align_Err}, 32'd1);
    chk("err2_addr", Err_Addr, 32'h0000_0102);
    chk("err2_mvalid", {31'd0, Mem_Valid}, 32'd0);
    drive(1'b1, 32'h0000_0000, 32'h3333_3333, 2'b11);
    tick();
    chk("err3_pulse", {31'd0, Align_Err}, 32'd1);
    chk("err3_addr", Err_Addr, 32'h0000_0000);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    chk("err_end_pulse", {31'd0, Align_Err}, 32'd0);
    chk("err_end_mvalid", {31'd0, Mem_Valid}, 32'd0);
    chk("err_end_busy", {31'd0, Busy}, 32'd0);
    chk("err_end_ready", {31'd0, Req_Ready}, 32'd1);

    // Back-pressure and full
    Mem_Ready = 1'b0;
    drive(1'b1, 32'h0000_0400, 32'h0000_0011, 2'b00);
    tick();
    drive(1'b1, 32'h0000_0402, 32'h0000_2222, 2'b01);
    tick();
    chk("full_ready", {31'd0, Req_Ready}, 32'd0);
    drive(1'b1, 32'h0000_0408, 32'h3333_3333, 2'b10);
    tick();
    chk("held_ready", {31'd0, Req_Ready}, 32'd0);
    chk_head("stall_a", 32'h0000_0400, 32'h1111_1111, 4'b0001);
    tick();
    chk_head("stall_b", 32'h0000_0400, 32'h1111_1111, 4'b0001);
    Mem_Ready = 1'b1;
    tick();
    chk_head("pop1", 32'h0000_0400, 32'h2222_2222, 4'b1100);
    chk("pop1_ready", {31'd0, Req_Ready}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk_head("pop2", 32'h0000_0408, 32'h3333_3333, 4'b1111);
    tick();
    chk("bp_empty", {31'd0, Mem_Valid}, 32'd0);

    // Simultaneous push/pop: 8 words back to back, occupancy stays at one
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h0000_0500 + 32'(k * 4), 32'hC0DE_0000 + 32'(k), 2'b10);
      tick();
      chk_head("stream", 32'h0000_0500 + 32'(k * 4), 32'hC0DE_0000 + 32'(k), 4'b1111);
      chk("stream_ready", {31'd0, Req_Ready}, 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    chk("stream_empty", {31'd0, Busy}, 32'd0);

    // Reset mid-operation: set a nonzero Err_Addr, fill, then reset
    drive(1'b1, 32'h0000_0777, 32'h0, 2'b11);
    tick();
    chk("pre_rst_eaddr", Err_Addr, 32'h0000_0777);
    Mem_Ready = 1'b0;
    drive(1'b1, 32'h0000_0700, 32'hAAAA_AAAA, 2'b10);
    tick();
    drive(1'b1, 32'h0000_0704, 32'hBBBB_BBBB, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk("pre_rst_full", {31'd0, Req_Ready}, 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_mvalid", {31'd0, Mem_Valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
    chk("mid_rst_eaddr", Err_Addr, 32'd0);
    chk("mid_rst_be", {28'd0, Mem_BE}, 32'd0);
    drive(1'b1, 32'h0000_0603, 32'h0000_005A, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk_head("after_rst", 32'h0000_0600, 32'h5A5A_5A5A, 4'b1000);
    Mem_Ready = 1'b1;
    tick();
    chk("after_rst_alone", {31'd0, Mem_Valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
